// File: rtl/ni_flit_injector.sv
`default_nettype none
// ============================================================================
//  Module   : ni_flit_injector
//  Brief    : Network-interface flit injector. Turns a packet descriptor plus
//             payload words into HEAD/BODY/TAIL/HEADTAIL flits on one VC,
//             honouring the router's per-VC on/off, allocatable and error
//             signals. One packet in flight at a time.
//  Options  : NI_PKT_CNT_EN - adds pkt_cnt_o, a wrapping count of packets
//             completed (TAIL or HEADTAIL flits emitted).
//  Revision : 1.0 - initial release
// ============================================================================
module ni_flit_injector #(
   parameter  int VC_NUM  = 2,
   parameter  int DATA_W  = 32,
   parameter  int X_W     = 2,
   parameter  int Y_W     = 2,
   parameter  int MAX_LEN = 8,
   localparam int VC_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pkt_valid_i,
   output logic              pkt_ready_o,
   input  logic [VC_W-1:0]   pkt_vc_i,
   input  logic [X_W-1:0]    pkt_dst_x_i,
   input  logic [Y_W-1:0]    pkt_dst_y_i,
   input  logic [LEN_W-1:0]  pkt_len_i,
   input  logic              pl_valid_i,
   output logic              pl_ready_o,
   input  logic [DATA_W-1:0] pl_data_i,
   output logic              valid_flit_o,
   output logic [1:0]        flit_label_o,
   output logic [VC_W-1:0]   vc_id_o,
   output logic [DATA_W-1:0] flit_data_o,
   input  logic [VC_NUM-1:0] on_off_i,
   input  logic [VC_NUM-1:0] vc_allocatable_i,
   input  logic [VC_NUM-1:0] error_i,
   output logic              err_o,
   output logic              busy_o
`ifdef NI_PKT_CNT_EN
   ,
   output logic [15:0]       pkt_cnt_o
`endif
);

   localparam logic [1:0] LBL_HEAD     = 2'b00;
   localparam logic [1:0] LBL_BODY     = 2'b01;
   localparam logic [1:0] LBL_TAIL     = 2'b10;
   localparam logic [1:0] LBL_HEADTAIL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VC = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [VC_W-1:0]     vc_q, vc_d;
   logic [X_W-1:0]      dst_x_q, dst_x_d;
   logic [Y_W-1:0]      dst_y_q, dst_y_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic                err_q, err_d;
   logic                valid_q, valid_d;
   logic [1:0]          label_q, label_d;
   logic [VC_W-1:0]     vcid_q, vcid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                bad_desc;

   // A descriptor naming a non-existent VC or an oversize payload is dropped.
   assign bad_desc = (32'(pkt_vc_i) >= 32'(VC_NUM)) || (32'(pkt_len_i) > 32'(MAX_LEN));

   // Next-state, flit launch and handshake ready generation.
   always_comb begin
      state_d     = state_q;
      vc_d        = vc_q;
      dst_x_d     = dst_x_q;
      dst_y_d     = dst_y_q;
      len_d       = len_q;
      rem_d       = rem_q;
      err_d       = err_q | (|error_i);
      valid_d     = 1'b0;
      label_d     = label_q;
      vcid_d      = vcid_q;
      data_d      = data_q;
      pkt_ready_o = 1'b0;
      pl_ready_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // rst_n gating keeps ready low while reset is held.
            pkt_ready_o = rst_n & ~err_q;
            if (pkt_valid_i && pkt_ready_o) begin
               if (bad_desc) begin
                  err_d = 1'b1;
               end else begin
                  vc_d    = pkt_vc_i;
                  dst_x_d = pkt_dst_x_i;
                  dst_y_d = pkt_dst_y_i;
                  len_d   = pkt_len_i;
                  state_d = ST_WAIT_VC;
               end
            end
         end
         ST_WAIT_VC: begin
            if (vc_allocatable_i[vc_q] && on_off_i[vc_q]) begin
               valid_d = 1'b1;
               label_d = (len_q == '0) ? LBL_HEADTAIL : LBL_HEAD;
               vcid_d  = vc_q;
               data_d  = '0;
               data_d[X_W+Y_W-1:0] = {dst_x_q, dst_y_q};
               if (len_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  rem_d   = len_q;
                  state_d = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            pl_ready_o = on_off_i[vc_q];
            if (pl_valid_i && pl_ready_o) begin
               valid_d = 1'b1;
               label_d = (rem_q == LEN_W'(1)) ? LBL_TAIL : LBL_BODY;
               vcid_d  = vc_q;
               data_d  = pl_data_i;
               rem_d   = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, packet context and registered flit outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vc_q    <= '0;
         dst_x_q <= '0;
         dst_y_q <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         label_q <= LBL_HEAD;
         vcid_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         vc_q    <= vc_d;
         dst_x_q <= dst_x_d;
         dst_y_q <= dst_y_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         label_q <= label_d;
         vcid_q  <= vcid_d;
         data_q  <= data_d;
      end
   end

   assign valid_flit_o = valid_q;
   assign flit_label_o = label_q;
   assign vc_id_o      = vcid_q;
   assign flit_data_o  = data_q;
   assign err_o        = err_q;
   assign busy_o       = (state_q != ST_IDLE);

`ifdef NI_PKT_CNT_EN
   logic [15:0] pkt_cnt_q;

   // Count a packet once its closing flit is on the outputs; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt_q <= '0;
      end else if (valid_q && label_q[1]) begin
         pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
   end

   assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ni_flit_injector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ni_flit_injector
//  Brief    : Self-checking bench for ni_flit_injector. Directed timing cases
//             plus randomized traffic compared against a packet-level
//             scoreboard (expected flit list built per accepted descriptor).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ni_flit_injector;
   localparam int VC_NUM  = 2;
   localparam int DATA_W  = 32;
   localparam int X_W     = 2;
   localparam int Y_W     = 2;
   localparam int MAX_LEN = 8;
   localparam int VC_W    = 1;
   localparam int LEN_W   = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              pkt_valid_i = 1'b0;
   logic              pkt_ready_o;
   logic [VC_W-1:0]   pkt_vc_i = '0;
   logic [X_W-1:0]    pkt_dst_x_i = '0;
   logic [Y_W-1:0]    pkt_dst_y_i = '0;
   logic [LEN_W-1:0]  pkt_len_i = '0;
   logic              pl_valid_i = 1'b0;
   logic              pl_ready_o;
   logic [DATA_W-1:0] pl_data_i = '0;
   logic              valid_flit_o;
   logic [1:0]        flit_label_o;
   logic [VC_W-1:0]   vc_id_o;
   logic [DATA_W-1:0] flit_data_o;
   logic [VC_NUM-1:0] on_off_i = '0;
   logic [VC_NUM-1:0] vc_allocatable_i = '0;
   logic [VC_NUM-1:0] error_i = '0;
   logic              err_o;
   logic              busy_o;
`ifdef NI_PKT_CNT_EN
   logic [15:0]       pkt_cnt_o;
`endif

   always #5 clk = ~clk;

   ni_flit_injector #(
      .VC_NUM (VC_NUM), .DATA_W (DATA_W), .X_W (X_W), .Y_W (Y_W), .MAX_LEN (MAX_LEN)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pkt_valid_i      (pkt_valid_i),
      .pkt_ready_o      (pkt_ready_o),
      .pkt_vc_i         (pkt_vc_i),
      .pkt_dst_x_i      (pkt_dst_x_i),
      .pkt_dst_y_i      (pkt_dst_y_i),
      .pkt_len_i        (pkt_len_i),
      .pl_valid_i       (pl_valid_i),
      .pl_ready_o       (pl_ready_o),
      .pl_data_i        (pl_data_i),
      .valid_flit_o     (valid_flit_o),
      .flit_label_o     (flit_label_o),
      .vc_id_o          (vc_id_o),
      .flit_data_o      (flit_data_o),
      .on_off_i         (on_off_i),
      .vc_allocatable_i (vc_allocatable_i),
      .error_i          (error_i),
      .err_o            (err_o),
      .busy_o           (busy_o)
`ifdef NI_PKT_CNT_EN
      ,
      .pkt_cnt_o        (pkt_cnt_o)
`endif
   );

   typedef struct {
      logic [1:0]        lbl;
      logic [VC_W-1:0]   vc;
      logic [DATA_W-1:0] data;
   } flit_t;

   flit_t             expq[$];
   logic [DATA_W-1:0] plq[$];
   int                n_vec = 0;
   int                n_err = 0;
   int                tails = 0;
   bit                model_err = 0;

   bit                desc_pend = 0;
   logic [VC_W-1:0]   d_vc = '0;
   logic [X_W-1:0]    d_x = '0;
   logic [Y_W-1:0]    d_y = '0;
   logic [LEN_W-1:0]  d_len = '0;
   int                pl_base = -1;
   bit                pl_en = 1;
   logic [VC_NUM-1:0] onoff_nx = '1;
   logic [VC_NUM-1:0] alloc_nx = '1;
   logic [VC_NUM-1:0] errin_nx = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_desc(input int vc, input int x, input int y, input int len, input int base);
      d_vc      = VC_W'(vc);
      d_x       = X_W'(x);
      d_y       = Y_W'(y);
      d_len     = LEN_W'(len);
      pl_base   = base;
      desc_pend = 1;
   endtask

   // Reference model: an accepted descriptor expands into its full flit list.
   task automatic accept_desc();
      flit_t             f;
      logic [DATA_W-1:0] w;
      desc_pend = 0;
      if (int'(d_len) > MAX_LEN || int'(d_vc) >= VC_NUM) begin
         model_err = 1;
      end else begin
         f.lbl  = (d_len == 0) ? 2'b11 : 2'b00;
         f.vc   = d_vc;
         f.data = (DATA_W'(d_x) << Y_W) | DATA_W'(d_y);
         expq.push_back(f);
         for (int i = 0; i < int'(d_len); i++) begin
            w = (pl_base >= 0) ? DATA_W'(pl_base + i) : DATA_W'($urandom);
            plq.push_back(w);
            f.lbl  = (i == int'(d_len) - 1) ? 2'b10 : 2'b01;
            f.data = w;
            expq.push_back(f);
         end
      end
   endtask

   // One clock: drive just after the rising edge, observe at the falling edge.
   task automatic step();
      flit_t             f;
      logic [VC_NUM-1:0] prev_on, prev_al;
      prev_on = on_off_i;
      prev_al = vc_allocatable_i;
      @(posedge clk); #1;
      on_off_i         = onoff_nx;
      vc_allocatable_i = alloc_nx;
      error_i          = errin_nx;
      pkt_valid_i      = desc_pend;
      pkt_vc_i         = d_vc;
      pkt_dst_x_i      = d_x;
      pkt_dst_y_i      = d_y;
      pkt_len_i        = d_len;
      pl_valid_i       = pl_en && (plq.size() > 0);
      pl_data_i        = (plq.size() > 0) ? plq[0] : '0;
      @(negedge clk);
      check_val("err_o", err_o, model_err);
      if (model_err) check_val("ready_under_err", pkt_ready_o, 0);
      if (valid_flit_o) begin
         if (expq.size() == 0) begin
            check_val("extra_flit", 1, 0);
         end else begin
            f = expq.pop_front();
            check_val("flit_label", flit_label_o, f.lbl);
            check_val("flit_vc", vc_id_o, f.vc);
            check_val("flit_data", flit_data_o, f.data);
            check_val("flit_while_off", prev_on[f.vc], 1);
            if (f.lbl == 2'b00 || f.lbl == 2'b11) check_val("head_unalloc", prev_al[f.vc], 1);
            if (f.lbl[1]) tails++;
         end
      end
      if (pkt_valid_i && pkt_ready_o) accept_desc();
      if (pl_valid_i && pl_ready_o) void'(plq.pop_front());
      model_err = model_err | (|error_i);
   endtask

   task automatic clear_bench();
      expq.delete();
      plq.delete();
      desc_pend   = 0;
      model_err   = 0;
      tails       = 0;
      pkt_valid_i = 0;
      pl_valid_i  = 0;
      error_i     = '0;
      errin_nx    = '0;
      onoff_nx    = '1;
      alloc_nx    = '1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      clear_bench();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int pk;
      int cyc;
`ifdef NI_PKT_CNT_EN
      logic [15:0] c0;
`endif
      // ---------------- reset state ----------------
      #1 rst_n = 1'b0;
      #2;
      check_val("rst_valid", valid_flit_o, 0);
      check_val("rst_label", flit_label_o, 0);
      check_val("rst_vc", vc_id_o, 0);
      check_val("rst_data", flit_data_o, 0);
      check_val("rst_err", err_o, 0);
      check_val("rst_pkt_ready", pkt_ready_o, 0);
      check_val("rst_busy", busy_o, 0);
`ifdef NI_PKT_CNT_EN
      check_val("rst_cnt", pkt_cnt_o, 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ---------------- single HEADTAIL packet ----------------
      onoff_nx = 2'b11; alloc_nx = 2'b10;
      set_desc(1, 2, 3, 0, 0);
      step();
      check_val("t1_ready", pkt_ready_o, 1);
      step();
      check_val("t1_wait_valid", valid_flit_o, 0);
      check_val("t1_busy", busy_o, 1);
`ifdef NI_PKT_CNT_EN
      c0 = pkt_cnt_o;
`endif
      step();
      check_val("t1_head_valid", valid_flit_o, 1);
      check_val("t1_head_label", flit_label_o, 2'b11);
      check_val("t1_head_vc", vc_id_o, 1);
      check_val("t1_head_data", flit_data_o, 32'h0000_000B);
      check_val("t1_busy_done", busy_o, 0);
`ifdef NI_PKT_CNT_EN
      check_val("t1_cnt_same", pkt_cnt_o, c0);
`endif
      step();
      check_val("t1_idle_valid", valid_flit_o, 0);
      check_val("t1_label_hold", flit_label_o, 2'b11);
      check_val("t1_ready_next", pkt_ready_o, 1);
`ifdef NI_PKT_CNT_EN
      check_val("t1_cnt_inc", pkt_cnt_o, c0 + 16'd1);
`endif

      // ---------------- back-to-back 3-flit payload ----------------
      alloc_nx = 2'b11;
      set_desc(0, 1, 2, 3, 'hA);
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 3) check_val("t2_head_label", flit_label_o, 2'b00);
         if (k >= 3 && k <= 6) check_val("t2_valid", valid_flit_o, 1);
         if (k == 6) check_val("t2_tail_data", flit_data_o, 32'hC);
         if (k == 7) check_val("t2_idle_valid", valid_flit_o, 0);
      end

      // ---------------- on/off stall for 4 cycles after first BODY ----------------
      set_desc(0, 1, 2, 3, 'hA);
      for (int k = 1; k <= 11; k++) begin
         onoff_nx = (k >= 4 && k <= 7) ? 2'b10 : 2'b11;
         step();
         if (k >= 4 && k <= 7) check_val("t3_pl_ready_stall", pl_ready_o, 0);
         if (k >= 5 && k <= 8) check_val("t3_valid_stall", valid_flit_o, 0);
         if (k == 9) check_val("t3_resume_data", flit_data_o, 32'hB);
         if (k == 10) check_val("t3_tail_label", flit_label_o, 2'b10);
      end
      onoff_nx = 2'b11;

      // ---------------- VC not allocatable for 5 cycles ----------------
      set_desc(0, 3, 0, 1, 'h55);
      for (int k = 1; k <= 10; k++) begin
         alloc_nx = (k <= 6) ? 2'b10 : 2'b11;
         step();
         if (k >= 2 && k <= 7) check_val("t4_no_head", valid_flit_o, 0);
         if (k == 8) check_val("t4_head", valid_flit_o, 1);
         if (k == 9) check_val("t4_tail_data", flit_data_o, 32'h55);
      end
      alloc_nx = 2'b11;

      // ---------------- randomized traffic ----------------
      pk  = 0;
      cyc = 0;
      while ((pk < 60 || desc_pend || expq.size() > 0) && cyc < 20000) begin
         if (!desc_pend && pk < 60 && $urandom_range(0, 3) != 0) begin
            set_desc($urandom_range(0, VC_NUM - 1), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, MAX_LEN), -1);
            pk++;
         end
         onoff_nx[0] = ($urandom_range(0, 3) != 0);
         onoff_nx[1] = ($urandom_range(0, 3) != 0);
         alloc_nx[0] = ($urandom_range(0, 2) != 0);
         alloc_nx[1] = ($urandom_range(0, 2) != 0);
         pl_en       = ($urandom_range(0, 4) != 0);
         step();
         cyc++;
      end
      if (cyc >= 20000) check_val("rand_timeout", 1, 0);
      pl_en = 1; onoff_nx = 2'b11; alloc_nx = 2'b11;
      repeat (3) step();
      check_val("rand_drain", expq.size(), 0);
      check_val("rand_busy", busy_o, 0);
`ifdef NI_PKT_CNT_EN
      check_val("rand_cnt", pkt_cnt_o, 16'(tails));
`endif

      // ---------------- error pulse mid-packet ----------------
      set_desc(0, 3, 1, 3, 'h10);
      for (int k = 1; k <= 10; k++) begin
         errin_nx = (k == 4) ? 2'b01 : 2'b00;
         if (k == 7) set_desc(1, 0, 0, 0, 0);
         step();
         if (k == 5) check_val("t5_err_set", err_o, 1);
         if (k == 6) check_val("t5_tail_label", flit_label_o, 2'b10);
         if (k == 6) check_val("t5_tail_valid", valid_flit_o, 1);
         if (k >= 7) check_val("t5_refused", pkt_ready_o, 0);
      end
      check_val("t5_err_sticky", err_o, 1);
      reset_dut();

      // ---------------- oversize descriptor dropped ----------------
      set_desc(0, 1, 1, MAX_LEN + 1, 0);
      step();
      check_val("t6_accept", pkt_ready_o, 1);
      step();
      check_val("t6_busy", busy_o, 0);
      check_val("t6_err", err_o, 1);
      step();
      check_val("t6_no_flit", valid_flit_o, 0);
      reset_dut();

      // ---------------- asynchronous reset mid-packet ----------------
      set_desc(1, 2, 2, 5, 'h100);
      repeat (4) step();
      check_val("t7_midpkt", busy_o, 1);
      #2 rst_n = 1'b0;
      clear_bench();
      #1;
      check_val("t7_valid", valid_flit_o, 0);
      check_val("t7_label", flit_label_o, 0);
      check_val("t7_vc", vc_id_o, 0);
      check_val("t7_data", flit_data_o, 0);
      check_val("t7_busy", busy_o, 0);
      check_val("t7_ready", pkt_ready_o, 0);
`ifdef NI_PKT_CNT_EN
      check_val("t7_cnt", pkt_cnt_o, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      set_desc(0, 1, 0, 0, 0);
      repeat (4) step();
      check_val("t7_recover_drain", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
